iopad_in_cond: RTL and testbench

IOPAD_IN_COND -- requirements
Module: iopad_in_cond

---
 rtl/iopad_in_cond.sv | 118 +++++++++++
 tb/tb_iopad_in_cond.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iopad_in_cond.sv
// Pad-side conditioning for one bidirectional GPIO: registered transmit controls,
// receive synchronizer, length-programmable glitch filter, edge pulses, glitch counter.
module iopad_in_cond #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              oe,
  input  logic              dout,
  input  logic              pu_en,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              glitch_clr,
  input  logic              pad_c,
  output logic              pad_i,
  output logic              pad_oen,
  output logic              pad_ren,
  output logic              din,
  output logic              rise_p,
  output logic              fall_p,
  output logic [7:0]        glitch_cnt
);

  logic                   pad_i_q, pad_oen_q, pad_ren_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   din_q, din_d;
  logic                   din_dly_q;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             glitch_q, glitch_d;
  logic                   glitch_hit;
  logic                   frozen;
  logic                   s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_i_q   <= 1'b0;
      pad_oen_q <= 1'b1;
      pad_ren_q <= 1'b0;
    end else begin
      pad_i_q   <= dout;
      pad_oen_q <= ~oe;
      pad_ren_q <= ~pu_en;
    end
  end

  // pad_c lands directly in the first flop; nothing combinational before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_c};
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign frozen = ~pad_oen_q;

  // '>=' lets a shortened filt_len release a count already past the new limit.
  always_comb begin
    din_d      = din_q;
    cnt_d      = cnt_q;
    glitch_hit = 1'b0;
    if (frozen) begin
      cnt_d = '0;
    end else if (s == din_q) begin
      cnt_d      = '0;
      glitch_hit = (cnt_q != '0);
    end else if (cnt_q < filt_len) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      din_d = s;
      cnt_d = '0;
    end
  end

  always_comb begin
    rise_d = ~frozen & din_q & ~din_dly_q;
    fall_d = ~frozen & ~din_q & din_dly_q;
  end

  always_comb begin
    glitch_d = glitch_q;
    if (glitch_clr) begin
      glitch_d = 8'd0;
    end else if (glitch_hit && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_q     <= 1'b0;
      din_dly_q <= 1'b0;
      cnt_q     <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      glitch_q  <= 8'd0;
    end else begin
      din_q     <= din_d;
      din_dly_q <= din_q;
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      glitch_q  <= glitch_d;
    end
  end

  assign pad_i      = pad_i_q;
  assign pad_oen    = pad_oen_q;
  assign pad_ren    = pad_ren_q;
  assign din        = din_q;
  assign rise_p     = rise_q;
  assign fall_p     = fall_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_iopad_in_cond.sv
// Directed bench for iopad_in_cond: pad-history model checked every cycle, plus
// hand-computed latency, glitch, freeze and reset expectations.
module tb_iopad_in_cond;
  localparam int SYNC = 2;
  localparam int FW   = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          oe = 1'b0, dout = 1'b0, pu_en = 1'b0, glitch_clr = 1'b0, pad_c = 1'b0;
  logic [FW-1:0] filt_len = '0;
  logic          pad_i, pad_oen, pad_ren, din, rise_p, fall_p;
  logic [7:0]    glitch_cnt;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  iopad_in_cond #(.SYNC_STAGES(SYNC), .FILT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .oe(oe), .dout(dout), .pu_en(pu_en),
    .filt_len(filt_len), .glitch_clr(glitch_clr), .pad_c(pad_c),
    .pad_i(pad_i), .pad_oen(pad_oen), .pad_ren(pad_ren), .din(din),
    .rise_p(rise_p), .fall_p(fall_p), .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: s is simply the pad value sampled SYNC edges ago; din flips once the
  // mismatch has persisted beyond filt_len edges.
  bit ph[$];
  bit m_pad_i, m_oen = 1'b1, m_ren, m_din, m_rise, m_fall, m_chg;
  bit m_s, m_frozen, m_hit;
  int m_run, m_gl;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph.delete();
      m_pad_i = 0; m_oen = 1; m_ren = 0; m_din = 0;
      m_rise = 0; m_fall = 0; m_chg = 0; m_run = 0; m_gl = 0;
    end else begin
      m_s      = (ph.size() >= SYNC) ? ph[ph.size() - SYNC] : 1'b0;
      m_frozen = !m_oen;
      m_rise   = !m_frozen && m_chg && m_din;
      m_fall   = !m_frozen && m_chg && !m_din;
      m_chg    = 0;
      m_hit    = 0;
      if (m_frozen) begin
        m_run = 0;
      end else if (m_s != m_din) begin
        if (m_run >= int'(filt_len)) begin
          m_din = m_s; m_run = 0; m_chg = 1;
        end else begin
          m_run++;
        end
      end else begin
        m_hit = (m_run != 0);
        m_run = 0;
      end
      if (glitch_clr) m_gl = 0;
      else if (m_hit && m_gl < 255) m_gl++;
      m_pad_i = dout;
      m_oen   = !oe;
      m_ren   = !pu_en;
      ph.push_back(pad_c);
      if (ph.size() > 8) void'(ph.pop_front());
    end
  end

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      check("m_pad_i", pad_i, m_pad_i);
      check("m_pad_oen", pad_oen, m_oen);
      check("m_pad_ren", pad_ren, m_ren);
      check("m_din", din, m_din);
      check("m_rise", rise_p, m_rise);
      check("m_fall", fall_p, m_fall);
      check("m_glitch", glitch_cnt, m_gl);
      check("m_not_both", rise_p & fall_p, 1'b0);
    end
  end

  logic [15:0] pat;
  int rc, re;

  initial begin
    pat = 16'hB38B;
    #1 rst_n = 1'b0;
    #1;
    check("rst_pad_i", pad_i, 1'b0);
    check("rst_pad_oen", pad_oen, 1'b1);
    check("rst_pad_ren", pad_ren, 1'b0);
    check("rst_din", din, 1'b0);
    check("rst_rise", rise_p, 1'b0);
    check("rst_fall", fall_p, 1'b0);
    check("rst_glitch", glitch_cnt, 8'd0);
    cmp_en   = 1'b1;
    filt_len = 4'd3;
    pu_en    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // filt_len=3: din rises 6 edges after pad, pulse on edge 7 only
    pad_c = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      check("lat_din", din, (i >= 6));
      check("lat_rise", rise_p, (i == 7));
    end
    repeat (2) @(negedge clk);
    pad_c = 1'b0;
    repeat (10) @(negedge clk);

    // 2-cycle and 3-cycle pulses are both shorter than filt_len+1
    pad_c = 1'b1;
    repeat (2) @(negedge clk);
    pad_c = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch2_cnt", glitch_cnt, 8'd1);
    check("glitch2_din", din, 1'b0);
    pad_c = 1'b1;
    repeat (3) @(negedge clk);
    pad_c = 1'b0;
    repeat (8) @(negedge clk);
    check("glitch3_cnt", glitch_cnt, 8'd2);
    check("glitch3_din", din, 1'b0);

    // bypass: din follows pad with 3-cycle latency
    filt_len = 4'd0;
    repeat (4) @(negedge clk);
    pad_c = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      check("byp_din", din, (i >= 3));
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pad_c = pat[i];
    end
    @(negedge clk);
    pad_c = 1'b0;
    repeat (6) @(negedge clk);
    check("byp_glitch", glitch_cnt, 8'd2);

    // saturation
    filt_len = 4'd5;
    for (int n = 0; n < 300; n++) begin
      pad_c = 1'b1;
      @(negedge clk);
      pad_c = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    check("sat_glitch", glitch_cnt, 8'd255);

    // clear on the same edge that a glitch is detected
    pad_c = 1'b1;
    @(negedge clk);
    pad_c = 1'b0;
    repeat (2) @(negedge clk);
    glitch_clr = 1'b1;
    @(negedge clk);
    glitch_clr = 1'b0;
    check("clr_glitch", glitch_cnt, 8'd0);
    repeat (4) @(negedge clk);

    // driving pad: filter frozen, TX follows dout
    filt_len = 4'd0;
    oe = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dout  = pat[i];
      pad_c = ~pat[i];
      @(negedge clk);
    end
    pad_c = 1'b1;
    repeat (3) @(negedge clk);
    check("frz_oen", pad_oen, 1'b0);
    check("frz_din", din, 1'b0);
    oe = 1'b0;
    repeat (8) @(negedge clk);
    check("unfrz_din", din, 1'b1);
    check("unfrz_oen", pad_oen, 1'b1);

    // one glitch so reset has a nonzero count to clear
    filt_len = 4'd5;
    dout  = 1'b1;
    pu_en = 1'b0;
    pad_c = 1'b0;
    @(negedge clk);
    pad_c = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_glitch", glitch_cnt, 8'd1);

    // async reset while cnt=2, din=1
    pad_c = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pad_i", pad_i, 1'b0);
    check("arst_pad_oen", pad_oen, 1'b1);
    check("arst_pad_ren", pad_ren, 1'b0);
    check("arst_din", din, 1'b0);
    check("arst_rise", rise_p, 1'b0);
    check("arst_fall", fall_p, 1'b0);
    check("arst_glitch", glitch_cnt, 8'd0);
    pad_c = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    rc = 0;
    re = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rise_p) begin
        rc++;
        re = i;
      end
    end
    check("rel_rise_count", rc, 1);
    check("rel_rise_edge", re, 9);

    // shrink filt_len mid-count
    @(negedge clk);
    filt_len = 4'd10;
    pad_c = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("shrink_hold", din, 1'b1);
    @(negedge clk);
    filt_len = 4'd2;
    @(posedge clk); #1;
    check("shrink_din", din, 1'b0);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
